// File: rtl/seq_mag_comparator_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states and the
// per-digit result code passed from the slice comparator to the control FSM.
package seq_mag_comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_EQ = 2'b00,
    RES_GT = 2'b01,
    RES_LT = 2'b10
  } res_t;

endpackage

// File: rtl/mc_digit_cmp.sv
// Combinational DIGIT-bit unsigned magnitude comparator returning a result code.
module mc_digit_cmp
  import seq_mag_comparator_pkg::*;
#(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output res_t             o_res_c
);

  always_comb begin
    o_res_c = RES_EQ;
    if (i_a > i_b) begin
      o_res_c = RES_GT;
    end else if (i_a < i_b) begin
      o_res_c = RES_LT;
    end
  end

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, with
// signed/unsigned mode, start/busy/done handshake and optional early exit.
module seq_mag_comparator
  import seq_mag_comparator_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DIGIT      = 2,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_signed_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_a_gt_b,
  output logic             o_a_eq_b,
  output logic             o_a_lt_b
);

  localparam int unsigned NUM_DIGITS = WIDTH / DIGIT;
  localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, w_a_nxt;
  logic [WIDTH-1:0]   r_b, w_b_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  res_t               r_first, w_first_nxt;
  logic               r_found, w_found_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_gt, w_gt_nxt;
  logic               r_eq, w_eq_nxt;
  logic               r_lt, w_lt_nxt;

  logic [WIDTH-1:0]   w_msb_mask;
  logic [31:0]        w_shift;
  logic [DIGIT-1:0]   w_a_dig;
  logic [DIGIT-1:0]   w_b_dig;
  res_t               w_dig_res;
  res_t               w_dec_res;
  logic               w_last;
  logic               w_early;

  // Flipping both MSBs maps two's complement onto offset binary, so the
  // unsigned digit scan yields the signed order.
  assign w_msb_mask = WIDTH'(i_signed_mode) << (WIDTH - 1);

  assign w_shift = 32'(r_idx) * DIGIT;
  assign w_a_dig = DIGIT'(r_a >> w_shift);
  assign w_b_dig = DIGIT'(r_b >> w_shift);
  assign w_last  = (r_idx == '0);
  assign w_early = (EARLY_EXIT != 0);

  mc_digit_cmp #(
    .DIGIT (DIGIT)
  ) u_digit_cmp (
    .i_a     (w_a_dig),
    .i_b     (w_b_dig),
    .o_res_c (w_dig_res)
  );

  // Without early exit the first difference seen wins over later digits.
  assign w_dec_res = r_found ? r_first : w_dig_res;

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_idx_nxt   = r_idx;
    w_first_nxt = r_first;
    w_found_nxt = r_found;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_gt_nxt    = r_gt;
    w_eq_nxt    = r_eq;
    w_lt_nxt    = r_lt;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_a_nxt     = i_a ^ w_msb_mask;
          w_b_nxt     = i_b ^ w_msb_mask;
          w_idx_nxt   = IDX_W'(NUM_DIGITS - 1);
          w_first_nxt = RES_EQ;
          w_found_nxt = 1'b0;
          w_gt_nxt    = 1'b0;
          w_eq_nxt    = 1'b0;
          w_lt_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_COMPARE;
        end
      end

      ST_COMPARE: begin
        if ((w_early && (w_dig_res != RES_EQ)) || w_last) begin
          w_gt_nxt    = (w_dec_res == RES_GT);
          w_eq_nxt    = (w_dec_res == RES_EQ);
          w_lt_nxt    = (w_dec_res == RES_LT);
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_idx_nxt = r_idx - IDX_W'(1);
          if (!r_found && (w_dig_res != RES_EQ)) begin
            w_found_nxt = 1'b1;
            w_first_nxt = w_dig_res;
          end
        end
      end

      ST_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_first <= RES_EQ;
      r_found <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_idx   <= w_idx_nxt;
      r_first <= w_first_nxt;
      r_found <= w_found_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_gt    <= w_gt_nxt;
      r_eq    <= w_eq_nxt;
      r_lt    <= w_lt_nxt;
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_a_gt_b = r_gt;
  assign o_a_eq_b = r_eq;
  assign o_a_lt_b = r_lt;

endmodule

// File: doc/seq_mag_comparator.md
# seq_mag_comparator

Parametrised, multi-cycle magnitude comparator that examines two WIDTH-bit operands MSB-first, DIGIT bits per clock. It is the sequential successor to the combinational 2-/4-bit comparators. It adds arbitrary width, a signed/unsigned mode, a start/busy/done handshake and optional early termination on the first differing digit. It sits behind any datapath that needs a compare result without a wide combinational carry/compare chain.

## Interface
- WIDTH, 8: operand width in bits. Must be a multiple of DIGIT.
- DIGIT, 2: bits compared per cycle. NUM_DIGITS = WIDTH/DIGIT.
- EARLY_EXIT, 1: 1 = finish on the first differing digit; 0 = always scan all digits.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a compare; accepted only when busy=0.
- signed_mode  in  1  1 = two's-complement compare; 0 = unsigned.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- busy  out  1  high while an operation is in flight, including the done cycle.
- done  out  1  single-cycle pulse; result flags are valid from this cycle.
- a_gt_b, a_eq_b, a_lt_b  out  1 each  registered result flags.

## Operation
- FSM states: IDLE, COMPARE, DONE.
- **IDLE**, start=1: capture a, b and signed_mode into internal registers, set digit index to the top digit, clear all three flags to 0, go to COMPARE.
  - In signed mode, invert the operand MSBs at capture. An unsigned compare of the offset-binary values then gives the signed order.
- **COMPARE**: each cycle, compare the indexed DIGIT-bit slice of A and B.
  - Slice differs and EARLY_EXIT=1: set a_gt_b or a_lt_b, go to DONE.
  - Slice differs and EARLY_EXIT=0: latch the first difference only; later digits never overwrite it. Continue.
  - Last digit reached with no difference: set a_eq_b. Otherwise set the latched gt/lt result. Go to DONE.
- **DONE**: done=1 for one cycle, then IDLE.
- Flags are one-hot once done is asserted. They hold until the next accepted start clears them.
- start while busy=1 is ignored. Operands are not resampled during an operation.
- Reset at any time, including mid-operation: state IDLE, busy=0, done=0, all flags 0. An aborted operation never produces a done pulse.

## Timing
- Reset values: busy=0, done=0, a_gt_b=0, a_eq_b=0, a_lt_b=0.
- Let E0 be the edge that samples start. busy=1 from E0.
- Digit j (1 = most significant) is evaluated at edge Ej. The flags update at the deciding edge Ej.
- done is high for the cycle following Ej. Latency is j edges: j = first differing digit with EARLY_EXIT=1, otherwise NUM_DIGITS.
- busy drops at the edge ending the done cycle. The earliest new accept is on the edge after that.
- Throughput: at most one operation per (latency + 2) cycles.

## Structure
- Shared package holds:
  - FSM state encodings (IDLE, COMPARE, DONE).
  - A 2-bit result code (EQ, GT, LT) used between the slice comparator and the FSM.
- One sub-module is natural: mc_digit_cmp, a combinational DIGIT-bit magnitude comparator that returns the result code. It is instantiated once and driven by the indexed slices.
- The top level holds the FSM, digit index counter, operand registers and result registers.

## Test plan
All scenarios use WIDTH=8, DIGIT=2 (NUM_DIGITS=4), EARLY_EXIT=1 unless stated.
1. Unsigned a=0x05, b=0x03 -> a_gt_b=1; digit 3 decides, so done 3 edges after start. Then a=b=0xA7 -> a_eq_b=1, done after 4 edges.
2. Signed a=0xFF (-1), b=0x01 -> a_lt_b=1, done after 1 edge. The same operands unsigned -> a_gt_b=1, done after 1 edge.
3. Signed a=0x80 (-128), b=0x7F -> a_lt_b=1. Signed a=0x00, b=0xFF -> a_gt_b=1.
4. EARLY_EXIT=0 instance, a=0xF0, b=0x00 -> a_gt_b=1, done exactly 4 edges after start. Later equal digits do not alter the result.
5. Pulse start with a=0x10, b=0x20, then start again 1 cycle later with a=0x20, b=0x10 -> the second start is ignored. Result: a_lt_b=1, exactly one done pulse.
6. Assert rst 2 cycles after start with a=0x00, b=0x01 -> busy=0 and flags 0 immediately, no done pulse. A new start after reset release completes normally.
